// File: rtl/wb_dual_master_arbiter.sv
// wb_dual_master_arbiter: round-robin two-master Wishbone classic arbiter with stall watchdog.
// Define WB_ARB_STATS_EN to add saturating grant/timeout statistics outputs.
module wb_dual_master_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO_CYCLES = 255,
  parameter logic [DW-1:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
`ifdef WB_ARB_STATS_EN
  output logic [15:0]     gnt0_cnt_o,
  output logic [15:0]     gnt1_cnt_o,
  output logic [7:0]      to_cnt_o,
`endif
  output logic            timeout_o
);
  localparam int CW = TO_CYCLES > 0 ? $clog2(TO_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
  state_t        r_state;
  logic [1:0]    r_grant;
  logic          r_last;
  logic          r_to;
  logic [CW-1:0] r_cnt;
  logic w_idle, w_g0, w_g1, w_ab, w_req0, w_req1, w_go0, w_go1, w_cyc, w_hit, w_abort;
  assign w_idle  = r_state == IDLE;
  assign w_g0    = r_state == GNT0;
  assign w_g1    = r_state == GNT1;
  assign w_ab    = r_state == ABORT;
  assign w_req0  = m0_cyc_i & m0_stb_i;
  assign w_req1  = m1_cyc_i & m1_stb_i;
  // on a tie the master that did not own the previous grant wins
  assign w_go0   = w_idle & w_req0 & (~w_req1 | r_last);
  assign w_go1   = w_idle & w_req1 & ~w_go0;
  assign w_cyc   = w_g0 ? m0_cyc_i : m1_cyc_i;
  assign w_hit   = TO_CYCLES != 0 && (int'(r_cnt) + 1 == TO_CYCLES);
  assign w_abort = (w_g0 | w_g1) & w_cyc & s_stb_o & ~s_ack_i & w_hit;
  assign s_cyc_o = w_g0 ? m0_cyc_i : w_g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = w_g0 ? m0_stb_i : w_g1 ? m1_stb_i : 1'b0;
  assign s_we_o  = w_g0 ? m0_we_i  : w_g1 ? m1_we_i  : 1'b0;
  assign s_sel_o = w_g0 ? m0_sel_i : w_g1 ? m1_sel_i : '0;
  assign s_adr_o = w_g0 ? m0_adr_i : w_g1 ? m1_adr_i : '0;
  assign s_dat_o = w_g0 ? m0_dat_i : w_g1 ? m1_dat_i : '0;
  assign m0_ack_o = (w_g0 & s_ack_i) | (w_ab & r_grant[0]);
  assign m1_ack_o = (w_g1 & s_ack_i) | (w_ab & r_grant[1]);
  assign m0_dat_o = w_g0 ? s_dat_i : (w_ab & r_grant[0]) ? TO_DATA : '0;
  assign m1_dat_o = w_g1 ? s_dat_i : (w_ab & r_grant[1]) ? TO_DATA : '0;
  assign grant_o   = r_grant;
  assign timeout_o = r_to;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_to <= w_abort;
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_state <= w_go0 ? GNT0 : w_go1 ? GNT1 : IDLE;
          r_grant <= {w_go1, w_go0};
          if (w_go0 | w_go1) r_last <= w_go1;
        end
        GNT0, GNT1: begin
          r_cnt <= (~w_cyc | s_ack_i | w_abort) ? '0 : s_stb_o ? r_cnt + 1'b1 : r_cnt;
          if (w_abort) r_state <= ABORT;
          else if (~w_cyc) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
`ifdef WB_ARB_STATS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      gnt0_cnt_o <= '0;
      gnt1_cnt_o <= '0;
      to_cnt_o   <= '0;
    end else begin
      if (w_go0 & ~&gnt0_cnt_o) gnt0_cnt_o <= gnt0_cnt_o + 1'b1;
      if (w_go1 & ~&gnt1_cnt_o) gnt1_cnt_o <= gnt1_cnt_o + 1'b1;
      if (w_abort & ~&to_cnt_o) to_cnt_o <= to_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// tb_wb_dual_master_arbiter: directed plus random stimulus against a transaction-rule reference model.
module tb_wb_dual_master_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] TOD = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc [2], stb [2], we [2];
  logic [3:0] sel [2];
  logic [31:0] adr [2], dat [2];
  logic s_ack;
  logic [31:0] s_dat;
  logic m0_ack, m1_ack, s_cyc, s_stb, s_we, timeout;
  logic [31:0] m0_dat, m1_dat, s_adr, s_wdat;
  logic [3:0] s_sel;
  logic [1:0] grant;
`ifdef WB_ARB_STATS_EN
  logic [15:0] g0c, g1c;
  logic [7:0] tcc;
`endif
  int n_chk = 0, n_err = 0;
  int own, stall, last, mg0, mg1, mto;
  bit abt;
  always #5 clk = ~clk;
  wb_dual_master_arbiter #(.AW(32), .DW(32), .TO_CYCLES(TO), .TO_DATA(TOD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_ack_o(m0_ack), .m0_dat_o(m0_dat),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_ack_o(m1_ack), .m1_dat_o(m1_dat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(grant),
`ifdef WB_ARB_STATS_EN
    .gnt0_cnt_o(g0c), .gnt1_cnt_o(g1c), .to_cnt_o(tcc),
`endif
    .timeout_o(timeout)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    own = -1; abt = 0; stall = 0; last = 1; mg0 = 0; mg1 = 0; mto = 0;
  endtask
  task automatic quiet();
    for (int m = 0; m < 2; m++) begin
      cyc[m] = 0; stb[m] = 0; we[m] = 0; sel[m] = 0; adr[m] = 0; dat[m] = 0;
    end
    s_ack = 0; s_dat = 0;
  endtask
  task automatic drive(input int m, input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc[m] = c; stb[m] = s; we[m] = w; sel[m] = 4'hF; adr[m] = a; dat[m] = d;
  endtask
  // compare one cycle against the rules, then advance the model past the clock edge
  task automatic step();
    int o;
    bit act, r0, r1;
    logic ea [2];
    logic [31:0] ed [2];
    o = own < 0 ? 0 : own;
    act = own >= 0 && !abt;
    #3;
    chk("grant", grant, own < 0 ? 64'd0 : 64'(1 << own));
    chk("s_cyc", s_cyc, act ? cyc[o] : 1'b0);
    chk("s_stb", s_stb, act ? stb[o] : 1'b0);
    chk("s_we", s_we, act ? we[o] : 1'b0);
    chk("s_sel", s_sel, act ? sel[o] : 4'h0);
    chk("s_adr", s_adr, act ? adr[o] : 32'h0);
    chk("s_dat", s_wdat, act ? dat[o] : 32'h0);
    for (int m = 0; m < 2; m++) begin
      ea[m] = own == m && ((act && s_ack) || abt);
      ed[m] = own != m ? 32'h0 : abt ? TOD : s_dat;
    end
    chk("m0_ack", m0_ack, ea[0]);
    chk("m1_ack", m1_ack, ea[1]);
    chk("m0_dat", m0_dat, ed[0]);
    chk("m1_dat", m1_dat, ed[1]);
    chk("timeout", timeout, abt);
    if (abt) begin
      own = -1; abt = 0;
    end else if (own < 0) begin
      r0 = cyc[0] & stb[0];
      r1 = cyc[1] & stb[1];
      own = (r0 && r1) ? 1 - last : r0 ? 0 : r1 ? 1 : -1;
      stall = 0;
      if (own >= 0) begin
        last = own;
        if (own == 0) mg0++; else mg1++;
      end
    end else if (!cyc[own]) begin
      own = -1; stall = 0;
    end else if (s_ack) stall = 0;
    else if (stb[own]) begin
      stall++;
      if (stall == TO) begin
        abt = 1; stall = 0; mto++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  initial begin
    quiet();
    model_reset();
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_ack0", m0_ack, 1'b0);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_to", timeout, 1'b0);
    do_reset();
    // single m0 write, slave acks two cycles after grant
    drive(0, 1, 1, 1, 32'h3000_0004, 32'h1234_5678);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_adr", s_adr, 32'h3000_0004);
    step();
    step();
    s_ack = 1; s_dat = 32'h0BAD_F00D;
    #1 chk("t1_ack", m0_ack, 1'b1);
    step();
    quiet();
    step();
    chk("t1_idle", grant, 2'b00);
    // simultaneous requests from reset: m0 first, then m1, then m0 again
    do_reset();
    drive(0, 1, 1, 0, 32'h10, 0);
    drive(1, 1, 1, 0, 32'h20, 0);
    step();
    chk("t2_first", grant, 2'b01);
    s_ack = 1; s_dat = 32'h1111_0000;
    step();
    s_ack = 0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t2_gap", grant, 2'b00);
    step();
    chk("t2_second", grant, 2'b10);
    s_ack = 1; s_dat = 32'h2222_0000;
    step();
    quiet();
    step();
    step();
    drive(0, 1, 1, 0, 32'h30, 0);
    drive(1, 1, 1, 0, 32'h40, 0);
    step();
    chk("t2_third", grant, 2'b01);
    quiet();
    step();
    step();
    // m1 keeps cyc across three strobes while m0 waits
    drive(1, 1, 1, 1, 32'h50, 32'h55);
    step();
    drive(0, 1, 1, 0, 32'h60, 0);
    for (int k = 0; k < 3; k++) begin
      s_ack = 1; s_dat = 32'h100 + k;
      adr[1] = 32'h50 + k;
      step();
      s_ack = 0;
      step();
      chk("t3_hold", grant, 2'b10);
    end
    drive(1, 0, 0, 0, 0, 0);
    step();
    step();
    chk("t3_m0", grant, 2'b01);
    quiet();
    step();
    step();
    // slave never acks an m0 read: abort after TO stalled cycles
    drive(0, 1, 1, 0, 32'h70, 0);
    step();
    repeat (TO) step();
    chk("t4_to", timeout, 1'b1);
    chk("t4_ack", m0_ack, 1'b1);
    chk("t4_dat", m0_dat, TOD);
    chk("t4_scyc", s_cyc, 1'b0);
    chk("t4_grant", grant, 2'b01);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t4_pulse", timeout, 1'b0);
    s_ack = 1; s_dat = 32'h7777_7777;
    step();
    quiet();
    // ack arrives in the cycle the watchdog would fire
    drive(0, 1, 1, 0, 32'h80, 0);
    step();
    repeat (TO - 1) step();
    s_ack = 1; s_dat = 32'hCAFE_0001;
    step();
    chk("t5_noto", timeout, 1'b0);
    quiet();
    step();
    step();
    // asynchronous reset in the middle of a GNT1 transaction
    drive(1, 1, 1, 1, 32'h90, 32'h99);
    step();
    step();
    s_ack = 1;
    rst = 1;
    #1;
    chk("t6_grant", grant, 2'b00);
    chk("t6_scyc", s_cyc, 1'b0);
    chk("t6_sstb", s_stb, 1'b0);
    chk("t6_ack1", m1_ack, 1'b0);
    model_reset();
    quiet();
    @(posedge clk);
    #1 rst = 0;
    drive(0, 1, 1, 0, 32'hA0, 0);
    drive(1, 1, 1, 0, 32'hB0, 0);
    step();
    chk("t6_after", grant, 2'b01);
    quiet();
    step();
    step();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        cyc[m] = cyc[m] ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
        stb[m] = cyc[m] & ($urandom_range(3) != 0);
        we[m] = 1'($urandom);
        sel[m] = 4'($urandom);
        adr[m] = $urandom;
        dat[m] = $urandom;
      end
      s_ack = $urandom_range(2) == 0;
      s_dat = $urandom;
      step();
    end
`ifdef WB_ARB_STATS_EN
    chk("st_g0", g0c, 16'(mg0));
    chk("st_g1", g1c, 16'(mg1));
    chk("st_to", tcc, 8'(mto));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
